// File: rtl/bnn_pkg.sv
// Shared types for the BNN output-feature writer.
// Build option: OF_SAT_EN selects saturating accumulation.
package bnn_pkg;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } of_state_t;

  localparam int PACK_W = 32;
endpackage

// File: rtl/of_binarize_writer_if.sv
// Psum beat stream in, packed BRAM word writes out.
// Build option: OF_SAT_EN (see of_binarize_writer).
interface of_binarize_writer_if
  import bnn_pkg::*;
#(
  parameter int PSUM_W = 10,
  parameter int ADDR_W = 16
);
  logic                     psum_valid;
  logic signed [PSUM_W-1:0] psum;
  logic                     first_channel;
  logic                     last_channel;
  logic                     of_we;
  logic [ADDR_W-1:0]        of_addr;
  logic [PACK_W-1:0]        of_wdata;

  modport master (
    output psum_valid, psum,
    output first_channel, last_channel,
    input  of_we, of_addr, of_wdata
  );

  modport slave (
    input  psum_valid, psum,
    input  first_channel, last_channel,
    output of_we, of_addr, of_wdata
  );
endinterface

// File: rtl/of_bit_packer.sv
// Collects binarized pixel bits into a 32-bit word.
// Build option: OF_SAT_EN (no effect here).
module of_bit_packer
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              bit_en,
  input  logic              bit_in,
  input  logic [4:0]        bit_cnt,
  input  logic              flush,
  output logic              full,
  output logic [PACK_W-1:0] word
);
  logic [PACK_W-1:0] pack;

  assign full = (bit_cnt == 5'd31);
  assign word = pack
    | (PACK_W'(bit_in) << bit_cnt);

  // once a word is handed off, restart empty
  always_ff @(posedge clk) begin
    if (rst || clear)
      pack <= '0;
    else if (bit_en)
      pack <= flush ? '0 : word;
  end
endmodule

// File: rtl/of_binarize_writer.sv
// Accumulates psums, binarizes, packs and writes words.
// Build option: OF_SAT_EN saturates acc, else it wraps.
module of_binarize_writer
  import bnn_pkg::*;
#(
  parameter int PSUM_W = 10,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              out_size,
  input  logic signed [ACC_W-1:0] threshold,
  input  logic [ADDR_W-1:0]       base_addr,
  of_binarize_writer_if.slave     bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  of_state_t state;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] thr_q;
  logic [ADDR_W-1:0]       base_q;
  logic [ADDR_W-1:0]       word_cnt;
  logic [15:0]             total;
  logic [15:0]             pix_cnt;
  logic [4:0]              bit_cnt;
  logic                    pix_open;

  logic signed [ACC_W-1:0] psum_x;
  logic signed [ACC_W-1:0] add_r;
  logic signed [ACC_W-1:0] acc_next;
  logic                    bit_v;
  logic                    last_pix;
  logic                    pix_done;
  logic                    full;
  logic                    flush;
  logic [PACK_W-1:0]       word;

  assign psum_x = ACC_W'(bus.psum);

`ifdef OF_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_w;

  always_comb begin
    sum_w = {acc[ACC_W-1], acc}
      + {psum_x[ACC_W-1], psum_x};
    add_r = sum_w[ACC_W-1:0];
    // top two bits disagree on overflow
    if (sum_w[ACC_W] != sum_w[ACC_W-1])
      add_r = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  assign add_r = acc + psum_x;
`endif

  assign acc_next = bus.first_channel
    ? psum_x : add_r;
  assign bit_v    = (acc_next >= thr_q);
  assign last_pix = (pix_cnt == total - 16'd1);
  assign pix_done = (state == RUN)
    && bus.psum_valid && bus.last_channel;
  assign flush    = full || last_pix;

  of_bit_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == IDLE) && start),
    .bit_en  (pix_done),
    .bit_in  (bit_v),
    .bit_cnt (bit_cnt),
    .flush   (flush),
    .full    (full),
    .word    (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      thr_q        <= '0;
      base_q       <= '0;
      word_cnt     <= '0;
      total        <= '0;
      pix_cnt      <= '0;
      bit_cnt      <= '0;
      pix_open     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      bus.of_we    <= 1'b0;
      bus.of_addr  <= '0;
      bus.of_wdata <= '0;
    end else begin
      bus.of_we <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          thr_q    <= threshold;
          base_q   <= base_addr;
          total    <= 16'(out_size) * 16'(out_size);
          word_cnt <= '0;
          pix_cnt  <= '0;
          bit_cnt  <= '0;
          pix_open <= 1'b0;
          acc      <= '0;
          err      <= 1'b0;
          if (out_size == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: if (bus.psum_valid) begin
          acc      <= acc_next;
          pix_open <= !bus.last_channel;
          if (pix_open == bus.first_channel)
            err <= 1'b1;
          if (bus.last_channel) begin
            pix_cnt <= pix_cnt + 16'd1;
            bit_cnt <= flush ? 5'd0 : bit_cnt + 5'd1;
            if (flush) begin
              bus.of_we    <= 1'b1;
              bus.of_addr  <= base_q + word_cnt;
              bus.of_wdata <= word;
              word_cnt     <= word_cnt + 1'b1;
            end
            if (last_pix)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_of_binarize_writer.sv
// Directed bench for of_binarize_writer.
// Build option: OF_SAT_EN changes saturation expectations.
module tb_of_binarize_writer;
  import bnn_pkg::*;

`ifdef OF_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  out_size;
  logic [15:0] threshold;
  logic [15:0] base_addr;
  logic        busy, done, err;

  of_binarize_writer_if #(
    .PSUM_W(10), .ADDR_W(16)
  ) bif ();

  of_binarize_writer #(
    .PSUM_W(10), .ACC_W(16), .ADDR_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .out_size  (out_size),
    .threshold (threshold),
    .base_addr (base_addr),
    .bus       (bif),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bif.of_we) begin
      wa.push_back(bif.of_addr);
      wd.push_back(bif.of_wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_map(input logic [7:0] sz,
                           input logic [15:0] thr,
                           input logic [15:0] base);
    out_size  = sz;
    threshold = thr;
    base_addr = base;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int p,
                      input logic f,
                      input logic l);
    bif.psum_valid    = 1'b1;
    bif.psum          = 10'(p);
    bif.first_channel = f;
    bif.last_channel  = l;
    tick();
    bif.psum_valid    = 1'b0;
    bif.first_channel = 1'b0;
    bif.last_channel  = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    chk({tag, "_done"}, done_cnt, d0 + 1);
    tick();
  endtask

  task automatic chk_wr(string tag, int idx,
                        logic [15:0] a,
                        logic [31:0] d);
    if (wa.size() > idx) begin
      chk({tag, "_addr"}, wa[idx], a);
      chk({tag, "_data"}, wd[idx], d);
    end else begin
      chk({tag, "_nwr"}, wa.size(), idx + 1);
    end
  endtask

  task automatic one_px(string tag,
                        logic [15:0] thr,
                        logic exp_bit);
    clear_log();
    start_map(8'd1, thr, 16'h0040);
    beat(511, 1'b1, 1'b0);
    for (int i = 1; i < 69; i++)
      beat(511, 1'b0, 1'b0);
    beat(511, 1'b0, 1'b1);
    wait_done(tag);
    chk_wr(tag, 0, 16'h0040, {31'd0, exp_bit});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_size = '0;
    threshold = '0;
    base_addr = '0;
    bif.psum_valid = 1'b0;
    bif.psum = '0;
    bif.first_channel = 1'b0;
    bif.last_channel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", bif.of_we, 0);
    chk("rst_addr", bif.of_addr, 0);
    chk("rst_data", bif.of_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();

    // 2x2 map, one channel per pixel
    clear_log();
    start_map(8'd2, 16'd0, 16'h0010);
    chk("t1_busy", busy, 1);
    beat(5, 1'b1, 1'b1);
    beat(-3, 1'b1, 1'b1);
    beat(0, 1'b1, 1'b1);
    beat(-1, 1'b1, 1'b1);
    chk("t1_we", bif.of_we, 1);
    wait_done("t1");
    chk("t1_nwr", wa.size(), 1);
    chk_wr("t1", 0, 16'h0010, 32'h0000_0005);
    chk("t1_err", err, 0);
    chk("t1_busy_end", busy, 0);

    // 36 pixels, base at top of address space
    clear_log();
    start_map(8'd6, 16'd0, 16'hFFFF);
    for (int i = 0; i < 36; i++)
      beat(1, 1'b1, 1'b1);
    wait_done("t2");
    chk("t2_nwr", wa.size(), 2);
    chk_wr("t2a", 0, 16'hFFFF, 32'hFFFF_FFFF);
    chk_wr("t2b", 1, 16'h0000, 32'h0000_000F);
    if (wc.size() == 2)
      chk("t2_done_lat", done_cyc, wc[1] + 1);

    // 3 channels summing to -1
    clear_log();
    start_map(8'd1, 16'hFFFF, 16'h0005);
    beat(4, 1'b1, 1'b0);
    beat(-2, 1'b0, 1'b0);
    beat(-3, 1'b0, 1'b1);
    wait_done("t3a");
    chk_wr("t3a", 0, 16'h0005, 32'h1);
    clear_log();
    start_map(8'd1, 16'd0, 16'h0005);
    beat(4, 1'b1, 1'b0);
    beat(-2, 1'b0, 1'b0);
    beat(-3, 1'b0, 1'b1);
    wait_done("t3b");
    chk_wr("t3b", 0, 16'h0005, 32'h0);

    // 70 x 511 = 35770: sat 32767, wrap -29766
    one_px("t4a", 16'sd32767, SAT);
    one_px("t4b", -16'sd29765, SAT);
    one_px("t4c", -16'sd29766, 1'b1);

    // protocol errors, start during RUN
    clear_log();
    start_map(8'd1, 16'd0, 16'h0020);
    beat(3, 1'b0, 1'b0);
    chk("t5_err_first", err, 1);
    start_map(8'd5, 16'd0, 16'h0099);
    chk("t5_busy", busy, 1);
    chk("t5_err_keep", err, 1);
    beat(2, 1'b1, 1'b0);
    beat(1, 1'b0, 1'b1);
    wait_done("t5");
    chk("t5_nwr", wa.size(), 1);
    chk_wr("t5", 0, 16'h0020, 32'h1);
    chk("t5_err_sticky", err, 1);
    clear_log();
    start_map(8'd1, 16'd0, 16'h0021);
    chk("t5_err_clr", err, 0);
    beat(-5, 1'b1, 1'b1);
    wait_done("t5b");
    chk_wr("t5b", 0, 16'h0021, 32'h0);
    chk("t5b_err", err, 0);

    // empty map goes straight to done
    clear_log();
    start_map(8'd0, 16'd0, 16'h0030);
    chk("t0_done", done, 1);
    chk("t0_busy", busy, 0);
    tick();
    chk("t0_nwr", wa.size(), 0);

    // reset mid-map
    clear_log();
    start_map(8'd28, 16'd0, 16'h0000);
    for (int i = 0; i < 10; i++)
      beat(1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_we", bif.of_we, 0);
    chk("t6_addr", bif.of_addr, 0);
    chk("t6_data", bif.of_wdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err, 0);
    for (int i = 0; i < 30; i++)
      beat(1, 1'b1, 1'b1);
    tick();
    tick();
    chk("t6_nwr", wa.size(), 0);
    chk("t6_ndone", done_cnt, 0);
    chk("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
